twos_to_sign_mag: RTL and testbench
===================================

TWOS_TO_SIGN_MAG -- requirements
Module: twos_to_sign_mag

Interface
REQ-001 Parameter N, default 32, is the data word width in bits (N >= 2).
REQ-002 clk  input  1  Single clock; all state changes on the rising edge.
REQ-003 reset  input  1  Asynchronous, active-high reset.
REQ-004 in_valid  input  1  Xin carries a two's-complement word to convert.
REQ-005 in_ready  output  1  The block can accept a word.
REQ-006 Xin  input  N  Two's-complement input word.
REQ-007 out_valid  output  1  Sign, Mag and MinNeg hold a completed result.
REQ-008 out_ready  input  1  The consumer accepts the result.
REQ-009 Sign  output  1  Sign of the result (1 = negative).
REQ-010 Mag  output  N  Unsigned magnitude of Xin.
REQ-011 MinNeg  output  1  Xin was the most-negative value, 1 followed by N-1 zeros.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, CONV and DONE.
REQ-013 in_ready SHALL be 1 exactly when the state is IDLE; out_valid SHALL be 1 exactly when the state is DONE.
REQ-014 Acceptance SHALL occur on a rising edge where in_valid and in_ready are both 1; on that edge, Xin is captured into an internal N-bit shift register and Sign is set to Xin[N-1].
REQ-015 On acceptance of a word with Xin[N-1]=0, the block SHALL load Mag=Xin, MinNeg=0 and enter DONE on the same edge.
REQ-016 On acceptance of a word with Xin[N-1]=1, the block SHALL enter CONV on the same edge and clear the bit counter and the seen_one flag.
REQ-017 In CONV, one bit SHALL be processed per edge, LSB first: result bit = seen_one ? ~x : x, where x is the current input bit, and then seen_one |= x.
REQ-018 Each result bit SHALL be placed at the position of the bit it was computed from, so Mag equals the arithmetic negation of Xin modulo 2^N.
REQ-019 The N-th CONV edge after acceptance SHALL process bit N-1, complete Mag, and enter DONE; negative latency is therefore exactly N edges after the accepting edge.
REQ-020 On entry to DONE from CONV, MinNeg SHALL be 1 if Mag equals 1 followed by N-1 zeros, and 0 otherwise.
REQ-021 In DONE, Sign, Mag and MinNeg SHALL remain stable until the handshake out_valid & out_ready completes, and the block SHALL then return to IDLE on that edge.
REQ-022 The block SHALL NOT accept a new word on the same edge a result is consumed; the earliest next acceptance is the following edge.
REQ-023 in_valid SHALL be ignored outside IDLE, and Xin changes after acceptance SHALL NOT affect an in-progress conversion.
REQ-024 out_ready SHALL be ignored outside DONE.
REQ-025 Mag, Sign and MinNeg SHALL retain their last values in IDLE until the next acceptance.
REQ-026 The bit counter SHALL be ceil(log2 N) bits wide and SHALL NOT wrap during a conversion.

Reset
REQ-027 While reset=1, independent of clk, state SHALL be IDLE, and Mag, Sign, MinNeg, out_valid, the bit counter, seen_one and the shift register SHALL all be 0.
REQ-028 Reset asserted mid-CONV or in DONE SHALL discard the in-flight word with no partial result visible.
REQ-029 in_ready SHALL be 1 from reset onward, and the first acceptance SHALL be possible on the first rising edge after reset deasserts.

Verification
REQ-030 (N=32) Xin=0x0000007B accepted with out_ready=1 -> out_valid=1 in the cycle after the accepting edge, Mag=0x0000007B, Sign=0, MinNeg=0.
REQ-031 Xin=0xFFFFFF92 (-110) accepted -> in_ready=0 for 32 edges, then out_valid=1 with Mag=0x0000006E, Sign=1, MinNeg=0.
REQ-032 Xin=0xFFFFFFFF -> Mag=0x00000001, Sign=1; Xin=0x80000000 -> Mag=0x80000000, Sign=1, MinNeg=1; Xin=0 -> Mag=0, Sign=0.
REQ-033 Backpressure: result for -35 with out_ready=0 for 5 cycles and in_valid=1 with Xin=0x00000001 held throughout -> Mag=0x00000023 and Sign=1 held stable, no acceptance occurs, and the next word is accepted only after the out_ready handshake plus one edge.
REQ-034 reset pulsed on the 10th CONV edge of -110 -> outputs go to 0 immediately, in_ready=1 after release, and a following conversion of 0xFFFFFFF6 yields Mag=0x0000000A, Sign=1.
REQ-035 A random regression of at least 10,000 words with random valid/ready throttling SHALL be checked against a reference model: Sign=Xin[N-1], Mag=Sign ? -Xin : Xin (mod 2^N).

Source files
------------

// File: rtl/twos_to_sign_mag_if.sv
// Handshake bundle for the two's-complement to sign-magnitude converter.
// The producer/consumer side takes the master modport and the converter takes the slave modport.
interface twos_to_sign_mag_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] Xin;
  logic         out_valid;
  logic         out_ready;
  logic         Sign;
  logic [N-1:0] Mag;
  logic         MinNeg;

  modport master (
    output in_valid, Xin, out_ready,
    input  in_ready, out_valid, Sign, Mag, MinNeg
  );

  modport slave (
    input  in_valid, Xin, out_ready,
    output in_ready, out_valid, Sign, Mag, MinNeg
  );
endinterface

// File: rtl/twos_to_sign_mag.sv
// Converts a two's-complement word to sign-magnitude form.
// Non-negative words finish in one edge; negative words are negated serially, LSB first, over N edges.
module twos_to_sign_mag #(
  parameter int N = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  twos_to_sign_mag_if.slave    bus
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);
  localparam logic [N-1:0]  MIN_NEG  = {1'b1, {(N-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        r_state;
  state_t        w_nextState;
  logic [N-1:0]  r_shift;
  logic [N-1:0]  r_acc;
  logic [N-1:0]  r_mag;
  logic [CW-1:0] r_cnt;
  logic          r_seenOne;
  logic          r_sign;
  logic          r_minNeg;
  logic          w_lastBit;
  logic          w_resBit;
  logic [N-1:0]  w_accNext;

  // Negation trick: copy bits up to and including the first 1, invert every bit after it.
  assign w_lastBit = (r_cnt == LAST_CNT);
  assign w_resBit  = r_seenOne ? ~r_shift[0] : r_shift[0];
  assign w_accNext = {w_resBit, r_acc[N-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (bus.in_valid) w_nextState = bus.Xin[N-1] ? CONV : DONE;
      CONV: if (w_lastBit) w_nextState = DONE;
      DONE: if (bus.out_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (r_state == IDLE);
    bus.out_valid = (r_state == DONE);
  end

  // Partial results accumulate in r_acc so Mag keeps the previous result until a conversion completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift   <= '0;
      r_acc     <= '0;
      r_mag     <= '0;
      r_cnt     <= '0;
      r_seenOne <= 1'b0;
      r_sign    <= 1'b0;
      r_minNeg  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_shift   <= bus.Xin;
            r_sign    <= bus.Xin[N-1];
            r_cnt     <= '0;
            r_seenOne <= 1'b0;
            r_acc     <= '0;
            if (!bus.Xin[N-1]) begin
              r_mag    <= bus.Xin;
              r_minNeg <= 1'b0;
            end
          end
        end
        CONV: begin
          r_shift   <= {1'b0, r_shift[N-1:1]};
          r_acc     <= w_accNext;
          r_seenOne <= r_seenOne | r_shift[0];
          if (w_lastBit) begin
            r_mag    <= w_accNext;
            r_minNeg <= (w_accNext == MIN_NEG);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.Sign   = r_sign;
  assign bus.Mag    = r_mag;
  assign bus.MinNeg = r_minNeg;

endmodule

// File: tb/tb_twos_to_sign_mag.sv
// Self-checking bench for twos_to_sign_mag: a cycle-level timing model plus a result scoreboard,
// exercised with directed cases, backpressure, mid-conversion reset and a throttled random run.
module tb_twos_to_sign_mag;

  localparam int N = 32;
  localparam int M_IDLE = 0;
  localparam int M_CONV = 1;
  localparam int M_DONE = 2;

  typedef struct packed {
    logic         sign;
    logic         minNeg;
    logic [N-1:0] mag;
  } result_t;

  logic clk;
  logic reset;

  twos_to_sign_mag_if #(.N(N)) tbIf ();

  twos_to_sign_mag #(.N(N)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (tbIf.slave)
  );

  int      checkCount;
  int      errorCount;
  int      wordsDone;
  int      mState;
  int      mRemain;
  result_t lastExp;
  result_t expQ[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic result_t expectFor(input logic [N-1:0] x);
    result_t r;
    r.sign   = x[N-1];
    r.mag    = x[N-1] ? (~x + 1'b1) : x;
    r.minNeg = (x == {1'b1, {(N-1){1'b0}}});
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkResult(input string tag, input result_t e);
    checkOutput({tag, "_sign"}, 64'(tbIf.Sign), 64'(e.sign));
    checkOutput({tag, "_mag"}, 64'(tbIf.Mag), 64'(e.mag));
    checkOutput({tag, "_minneg"}, 64'(tbIf.MinNeg), 64'(e.minNeg));
  endtask

  // One clock cycle: drive inputs, check against the model, advance model, clock the DUT.
  task automatic applyStimulus(input logic inValid, input logic [N-1:0] xin, input logic outReady);
    result_t e;
    tbIf.in_valid  = inValid;
    tbIf.Xin       = xin;
    tbIf.out_ready = outReady;
    #1;
    checkOutput("in_ready", 64'(tbIf.in_ready), 64'(mState == M_IDLE));
    checkOutput("out_valid", 64'(tbIf.out_valid), 64'(mState == M_DONE));
    case (mState)
      M_IDLE: begin
        checkResult("idle_hold", lastExp);
        if (inValid) begin
          e = expectFor(xin);
          expQ.push_back(e);
          if (e.sign) begin
            mState  = M_CONV;
            mRemain = N;
          end else begin
            mState = M_DONE;
          end
        end
      end
      M_CONV: begin
        e = lastExp;
        e.sign = 1'b1;
        checkResult("conv_hold", e);
        mRemain--;
        if (mRemain == 0) mState = M_DONE;
      end
      default: begin
        if (expQ.size() != 0) begin
          checkResult("done", expQ[0]);
          if (outReady) begin
            lastExp = expQ.pop_front();
            wordsDone++;
            mState = M_IDLE;
          end
        end else begin
          checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd1);
          mState = M_IDLE;
        end
      end
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    tbIf.in_valid  = 1'b0;
    tbIf.out_ready = 1'b0;
    tbIf.Xin       = '0;
    reset = 1'b1;
    #1;
    checkOutput("rst_mag", 64'(tbIf.Mag), 64'd0);
    checkOutput("rst_sign", 64'(tbIf.Sign), 64'd0);
    checkOutput("rst_minneg", 64'(tbIf.MinNeg), 64'd0);
    checkOutput("rst_out_valid", 64'(tbIf.out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(tbIf.in_ready), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    mState  = M_IDLE;
    mRemain = 0;
    lastExp = '0;
    expQ.delete();
  endtask

  task automatic doWord(input logic [N-1:0] x);
    applyStimulus(1'b1, x, 1'b1);
    for (int i = 0; i < N + 4 && mState != M_IDLE; i++) begin
      applyStimulus(1'b0, N'($urandom), 1'b1);
    end
    checkOutput("word_complete", 64'(mState), 64'(M_IDLE));
  endtask

  initial begin
    logic [N-1:0] x;
    int           sel;
    int           cycles;
    checkCount = 0;
    errorCount = 0;
    wordsDone  = 0;
    reset          = 1'b1;
    tbIf.in_valid  = 1'b0;
    tbIf.out_ready = 1'b0;
    tbIf.Xin       = '0;
    @(posedge clk);
    #1;
    doReset();

    doWord(32'h0000007B);
    checkResult("pos_7b", '{sign: 1'b0, minNeg: 1'b0, mag: 32'h0000007B});
    doWord(32'hFFFFFF92);
    checkResult("neg_110", '{sign: 1'b1, minNeg: 1'b0, mag: 32'h0000006E});
    doWord(32'hFFFFFFFF);
    checkResult("neg_1", '{sign: 1'b1, minNeg: 1'b0, mag: 32'h00000001});
    doWord(32'h80000000);
    checkResult("min_neg", '{sign: 1'b1, minNeg: 1'b1, mag: 32'h80000000});
    doWord(32'h00000000);
    checkResult("zero", '{sign: 1'b0, minNeg: 1'b0, mag: 32'h00000000});

    // Backpressure with a competing word held on the input the whole time.
    applyStimulus(1'b1, 32'hFFFFFFDD, 1'b0);
    for (int i = 0; i < N + 2 && mState == M_CONV; i++) applyStimulus(1'b1, 32'h1, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h1, 1'b0);
    checkResult("bp_hold", '{sign: 1'b1, minNeg: 1'b0, mag: 32'h00000023});
    applyStimulus(1'b1, 32'h1, 1'b1);
    checkOutput("bp_no_accept_on_consume", 64'(tbIf.in_ready), 64'd1);
    applyStimulus(1'b1, 32'h1, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkResult("bp_next", '{sign: 1'b0, minNeg: 1'b0, mag: 32'h00000001});

    // Reset landing during the tenth conversion edge.
    applyStimulus(1'b1, 32'hFFFFFF92, 1'b0);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 32'h0, 1'b0);
    doReset();
    doWord(32'hFFFFFFF6);
    checkResult("after_rst", '{sign: 1'b1, minNeg: 1'b0, mag: 32'h0000000A});

    // Throttled random regression.
    wordsDone = 0;
    cycles    = 0;
    while (wordsDone < 10000 && cycles < 90000) begin
      sel = $urandom_range(0, 63);
      case (sel)
        0:       x = 32'h80000000;
        1:       x = 32'hFFFFFFFF;
        2:       x = $urandom | 32'h80000000;
        3:       x = 32'h0;
        default: x = $urandom & 32'h7FFFFFFF;
      endcase
      applyStimulus(($urandom_range(0, 7) != 0), x, ($urandom_range(0, 7) != 0));
      cycles++;
    end
    checkOutput("regress_words", 64'(wordsDone), 64'd10000);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
